spi_dac_receiver: RTL and testbench
===================================

SPI_DAC_RECEIVER -- requirements
Module: spi_dac_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of input synchronizer flops on CS, SCLK and SDI (legal values 2..4).
REQ-002 SHALL have parameter DATA_STEP, default 16, the expected 12-bit increment between consecutive data words.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port CS, input, 1 bit: frame select, active-low.
REQ-006 SHALL have port SCLK, input, 1 bit: serial clock; data is sampled on its rising edge.
REQ-007 SHALL have port SDI, input, 1 bit: serial data, MSB first, stable at SCLK rise.
REQ-008 SHALL have port word_valid, output, 1 bit: one-cycle strobe marking a complete 16-bit frame.
REQ-009 SHALL have port ctrl, output, 4 bits: received word bits [15:12].
REQ-010 SHALL have port data, output, 12 bits: received word bits [11:0].
REQ-011 SHALL have port frame_error, output, 1 bit: one-cycle strobe marking a malformed frame.
REQ-012 SHALL have port seq_error, output, 1 bit: one-cycle strobe for a sequence violation (only when the macro is defined, see Configuration).

Function
REQ-013 SHALL pass CS, SCLK and SDI through SYNC_STAGES flops, all with equal depth so they stay aligned; all edge detection uses the last stage against one extra registered copy.
REQ-014 SHALL run an FSM with three states:
- IDLE: CS high.
- RECV: CS low, counting SCLK rises.
- OVERRUN: more than 16 rises seen, waiting for CS high.
REQ-015 SHALL move IDLE->RECV on synchronized CS fall, clearing the 5-bit bit counter and the 16-bit shift register.
REQ-016 SHALL, in RECV, on each synchronized SCLK rise, shift SDI into the shift register LSB and increment the bit counter.
REQ-017 SHALL move RECV->OVERRUN on the 17th SCLK rise; SCLK rises in OVERRUN are ignored.
REQ-018 SHALL, on a CS rise in RECV with the bit counter at exactly 16:
- pulse word_valid for 1 cycle;
- load ctrl and data from the shift register on the same edge;
- return to IDLE.
REQ-019 SHALL, on a CS rise in RECV with the bit counter not equal to 16, or any CS rise in OVERRUN:
- pulse frame_error for 1 cycle;
- leave ctrl and data unchanged;
- return to IDLE.
REQ-020 SHALL assert word_valid or frame_error exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples CS high at the pin.
REQ-021 SHALL ignore SCLK edges while CS is high, and SHALL ignore an SCLK rise that is detected in the same cycle as the CS rise.
REQ-022 SHALL hold ctrl and data stable between word_valid pulses.
REQ-023 SHALL never assert word_valid and frame_error in the same cycle.
REQ-024 SHALL treat a CS fall as the start of a new frame even when it is detected in the cycle directly after a CS rise (minimum CS-high time of 1 clk).
REQ-025 SHALL capture correctly when SCLK high and low each last at least 1 clk period on the same clock, or at least 2 periods if SCLK comes from another clock.

Reset
REQ-026 SHALL, while rst_n is low, immediately force:
- state to IDLE;
- word_valid, frame_error and seq_error to 0;
- ctrl to 0 and data to 0;
- the bit counter, shift register and synchronizers to 0 (CS synchronizer stages to 1).
REQ-027 SHALL discard a frame interrupted by reset, and SHALL require a fresh CS fall after rst_n goes high before capturing.

Configuration
REQ-028 SHALL, when macro SPI_DAC_RECEIVER_SEQ_CHECK_EN is defined, check each word_valid word:
- keep the previous accepted data as a 12-bit register, reset to 0, with a first-word flag;
- pulse seq_error together with word_valid when data is not equal to (prev + DATA_STEP) mod 4096 and data is not 0;
- never flag the first word after reset;
- data equal to 0 is always accepted, as a source restart.
REQ-029 SHALL, when SPI_DAC_RECEIVER_SEQ_CHECK_EN is undefined, tie seq_error to 0 and synthesize no sequence logic.

Verification
REQ-030 SHALL check a 16-bit frame 0x100F with SCLK at clk/2 -> one word_valid, ctrl=0x1, data=0x00F, frame_error=0.
REQ-031 SHALL check a frame of 8 SCLK rises then CS high -> frame_error pulse, no word_valid, ctrl and data keep their previous values.
REQ-032 SHALL check a frame of 17 SCLK rises carrying 0x1FFF plus 1 bit -> OVERRUN, frame_error on CS rise, no word_valid.
REQ-033 SHALL check rst_n pulsed low after bit 9 of 0x1234, then a full frame 0x1ABC -> only one word_valid, data=0xABC, ctrl=0x1.
REQ-034 SHALL check, with the macro defined, frames 0x100F, 0x101F, 0x1030, 0x1000 -> seq_error only on 0x1030.
REQ-035 SHALL check frames 0x1FFF and 0x100F back-to-back with 1-clk CS high -> two word_valid pulses, and seq_error=0 with the macro defined (wrap 0xFFF+16 = 0x00F).

Source files
------------

// File: rtl/spi_dac_receiver.sv
// ----------------------------------------------------------------------------
// spi_dac_receiver
//   Receives 16-bit SPI frames (mode 0, MSB first) on the system clock and
//   splits them into a 4-bit control nibble and 12-bit data word.
//
// Parameters
//   SYNC_STAGES : input synchronizer depth for CS/SCLK/SDI (2..4)
//   DATA_STEP   : expected increment between consecutive data words
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   CS          : frame select, active low
//   SCLK        : serial clock, data sampled on its rising edge
//   SDI         : serial data, MSB first
//   word_valid  : 1-cycle strobe, complete 16-bit frame received
//   ctrl        : received word bits [15:12]
//   data        : received word bits [11:0]
//   frame_error : 1-cycle strobe, malformed frame (short or overrun)
//   seq_error   : 1-cycle strobe with word_valid on a sequence violation
//
// Optional feature
//   SPI_DAC_RECEIVER_SEQ_CHECK_EN : when defined, each received data word is
//   checked against (previous + DATA_STEP) mod 4096; 0 is always accepted.
//   When undefined, seq_error is tied low.
// ----------------------------------------------------------------------------
module spi_dac_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_STEP   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        CS,
   input  logic        SCLK,
   input  logic        SDI,
   output logic        word_valid,
   output logic [3:0]  ctrl,
   output logic [11:0] data,
   output logic        frame_error,
   output logic        seq_error
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_OVERRUN
   } state_t;

   // Input synchronizers and edge detection
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_sdi_sync;
   logic                   r_cs_d;
   logic                   r_sclk_d;
   logic [SYNC_STAGES:0]   r_vld;
   logic                   r_armed;
   logic                   r_cs_rise;
   logic                   r_cs_fall;
   logic                   r_sclk_rise;
   logic                   r_sdi_bit;

   logic w_cs_last;
   logic w_sclk_last;
   logic w_armed;

   assign w_cs_last   = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_last = r_sclk_sync[SYNC_STAGES-1];
   // r_vld tracks which synchronizer stages hold real pin samples rather than
   // reset values, so a CS held low across reset is not taken as a fresh fall.
   assign w_armed     = r_armed | (r_vld[SYNC_STAGES] & r_cs_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '0;
         r_sdi_sync  <= '0;
         r_cs_d      <= 1'b1;
         r_sclk_d    <= 1'b0;
         r_vld       <= '0;
         r_armed     <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_sdi_bit   <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
         r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
         r_cs_d      <= w_cs_last;
         r_sclk_d    <= w_sclk_last;
         r_vld       <= {r_vld[SYNC_STAGES-1:0], 1'b1};
         r_armed     <= w_armed;
         r_cs_rise   <= ~r_cs_d & w_cs_last;
         r_cs_fall   <= w_armed & r_cs_d & ~w_cs_last;
         r_sclk_rise <= ~r_sclk_d & w_sclk_last;
         r_sdi_bit   <= r_sdi_sync[SYNC_STAGES-1];
      end
   end

   // Frame FSM
   state_t      r_state, w_state_nxt;
   logic [4:0]  r_cnt, w_cnt_nxt;
   logic [15:0] r_shift, w_shift_nxt;
   logic        r_ok, w_ok;
   logic        r_bad, w_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_ok    <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_ok    <= w_ok;
         r_bad   <= w_bad;
      end
   end

   // CS rise takes priority over an SCLK rise seen in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_ok        = 1'b0;
      w_bad       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_cs_fall) begin
               w_state_nxt = ST_RECV;
               w_cnt_nxt   = '0;
               w_shift_nxt = '0;
            end
         end
         ST_RECV: begin
            if (r_cs_rise) begin
               w_state_nxt = ST_IDLE;
               if (r_cnt == 5'd16) w_ok  = 1'b1;
               else                w_bad = 1'b1;
            end else if (r_sclk_rise) begin
               if (r_cnt == 5'd16) begin
                  w_state_nxt = ST_OVERRUN;
               end else begin
                  w_shift_nxt = {r_shift[14:0], r_sdi_bit};
                  w_cnt_nxt   = r_cnt + 5'd1;
               end
            end
         end
         ST_OVERRUN: begin
            if (r_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_bad       = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output stage; r_shift is still the finished frame when r_ok is seen,
   // even if a new frame clears it on this same edge.
   logic        r_word_valid;
   logic        r_frame_error;
   logic [3:0]  r_ctrl;
   logic [11:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_valid  <= 1'b0;
         r_frame_error <= 1'b0;
         r_ctrl        <= '0;
         r_data        <= '0;
      end else begin
         r_word_valid  <= r_ok;
         r_frame_error <= r_bad;
         if (r_ok) begin
            r_ctrl <= r_shift[15:12];
            r_data <= r_shift[11:0];
         end
      end
   end

   assign word_valid  = r_word_valid;
   assign frame_error = r_frame_error;
   assign ctrl        = r_ctrl;
   assign data        = r_data;

`ifdef SPI_DAC_RECEIVER_SEQ_CHECK_EN
   localparam logic [11:0] LP_STEP = 12'(DATA_STEP);

   logic [11:0] r_prev;
   logic        r_first_pending;
   logic        r_seq_error;
   logic [11:0] w_new;
   logic [11:0] w_expect;

   assign w_new    = r_shift[11:0];
   assign w_expect = r_prev + LP_STEP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev          <= '0;
         r_first_pending <= 1'b1;
         r_seq_error     <= 1'b0;
      end else begin
         r_seq_error <= r_ok & ~r_first_pending & (w_new != '0) & (w_new != w_expect);
         if (r_ok) begin
            r_prev          <= w_new;
            r_first_pending <= 1'b0;
         end
      end
   end

   assign seq_error = r_seq_error;
`else
   assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_receiver.sv
// ----------------------------------------------------------------------------
// tb_spi_dac_receiver
//   Directed bench for spi_dac_receiver: normal frame, short frame, overrun,
//   reset mid-frame, back-to-back frames with wrap, and the sequence checker
//   when SPI_DAC_RECEIVER_SEQ_CHECK_EN is defined.
// ----------------------------------------------------------------------------
module tb_spi_dac_receiver;

   localparam int S    = 2;
   localparam int STEP = 16;
   // Strobe seen at the (S+3)th falling clk edge after CS is raised at a
   // falling edge: the next rising edge samples it, then S+2 more edges.
   localparam int EXP_LAT = S + 3;

`ifdef SPI_DAC_RECEIVER_SEQ_CHECK_EN
   localparam int SEQ_ON = 1;
`else
   localparam int SEQ_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        CS;
   logic        SCLK;
   logic        SDI;
   logic        word_valid;
   logic [3:0]  ctrl;
   logic [11:0] data;
   logic        frame_error;
   logic        seq_error;

   spi_dac_receiver #(.SYNC_STAGES(S), .DATA_STEP(STEP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .CS          (CS),
      .SCLK        (SCLK),
      .SDI         (SDI),
      .word_valid  (word_valid),
      .ctrl        (ctrl),
      .data        (data),
      .frame_error (frame_error),
      .seq_error   (seq_error)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Pulse monitor, sampled on the falling edge
   int          n_wv   = 0;
   int          n_fe   = 0;
   int          n_se   = 0;
   int          n_both = 0;
   logic [15:0] w_last = '0;
   logic [15:0] w_prev = '0;
   logic [15:0] se_word = '0;

   always @(negedge clk) begin
      if (word_valid) begin
         n_wv++;
         w_prev = w_last;
         w_last = {ctrl, data};
      end
      if (frame_error) n_fe++;
      if (seq_error) begin
         n_se++;
         se_word = {ctrl, data};
      end
      if (word_valid && frame_error) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [31:0] val, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         SDI  = val[i];
         SCLK = 1'b0;
         @(negedge clk);
         SCLK = 1'b1;
         @(negedge clk);
      end
      SCLK = 1'b0;
   endtask

   task automatic frame(input logic [31:0] val, input int nbits);
      CS = 1'b0;
      repeat (2) @(negedge clk);
      send_bits(val, nbits);
      repeat (2) @(negedge clk);
      CS = 1'b1;
   endtask

   // Bounded wait for the end-of-frame strobe; returns the falling-edge index
   // of its first appearance, or -1 if none within the window.
   task automatic wait_out(output int lat);
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (lat < 0 && (word_valid || frame_error)) lat = k;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   int lat;
   int b_wv, b_fe, b_se;

   initial begin
      rst_n = 1'b0;
      CS    = 1'b1;
      SCLK  = 1'b0;
      SDI   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_word_valid", 32'(word_valid), 0);
      chk("rst_frame_error", 32'(frame_error), 0);
      chk("rst_seq_error", 32'(seq_error), 0);
      chk("rst_ctrl", 32'(ctrl), 0);
      chk("rst_data", 32'(data), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Full frame 0x100F
      b_wv = n_wv; b_fe = n_fe; b_se = n_se;
      frame(32'h100F, 16);
      wait_out(lat);
      chk("good_latency", 32'(lat), 32'(EXP_LAT));
      chk("good_wv_count", 32'(n_wv - b_wv), 1);
      chk("good_fe_count", 32'(n_fe - b_fe), 0);
      chk("good_ctrl", 32'(ctrl), 32'h1);
      chk("good_data", 32'(data), 32'h00F);
      chk("good_se_count", 32'(n_se - b_se), 0);

      // Short frame: 8 rises
      b_wv = n_wv; b_fe = n_fe;
      frame(32'hA5, 8);
      wait_out(lat);
      chk("short_latency", 32'(lat), 32'(EXP_LAT));
      chk("short_fe_count", 32'(n_fe - b_fe), 1);
      chk("short_wv_count", 32'(n_wv - b_wv), 0);
      chk("short_ctrl_held", 32'(ctrl), 32'h1);
      chk("short_data_held", 32'(data), 32'h00F);

      // Overrun: 0x1FFF plus one extra bit
      b_wv = n_wv; b_fe = n_fe;
      frame(32'h3FFF, 17);
      wait_out(lat);
      chk("ovr_fe_count", 32'(n_fe - b_fe), 1);
      chk("ovr_wv_count", 32'(n_wv - b_wv), 0);
      chk("ovr_ctrl_held", 32'(ctrl), 32'h1);
      chk("ovr_data_held", 32'(data), 32'h00F);

      // Reset after 9 bits of 0x1234, CS held low through reset
      CS = 1'b0;
      repeat (2) @(negedge clk);
      send_bits(32'h1234 >> 7, 9);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_ctrl", 32'(ctrl), 0);
      chk("async_rst_data", 32'(data), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      b_wv = n_wv; b_fe = n_fe; b_se = n_se;
      repeat (5) @(negedge clk);
      CS = 1'b1;
      repeat (6) @(negedge clk);
      frame(32'h1ABC, 16);
      wait_out(lat);
      chk("rstmid_wv_count", 32'(n_wv - b_wv), 1);
      chk("rstmid_fe_count", 32'(n_fe - b_fe), 0);
      chk("rstmid_ctrl", 32'(ctrl), 32'h1);
      chk("rstmid_data", 32'(data), 32'hABC);
      chk("rstmid_se_count", 32'(n_se - b_se), 0);

      // Back-to-back 0x1FFF, 0x100F with one clk of CS high
      do_reset();
      b_wv = n_wv; b_fe = n_fe; b_se = n_se;
      frame(32'h1FFF, 16);
      @(negedge clk);
      frame(32'h100F, 16);
      wait_out(lat);
      chk("b2b_wv_count", 32'(n_wv - b_wv), 2);
      chk("b2b_fe_count", 32'(n_fe - b_fe), 0);
      chk("b2b_first_word", 32'(w_prev), 32'h1FFF);
      chk("b2b_second_word", 32'(w_last), 32'h100F);
      chk("b2b_se_count", 32'(n_se - b_se), 0);

      // Sequence 0x100F, 0x101F, 0x1030, 0x1000
      do_reset();
      b_wv = n_wv; b_fe = n_fe; b_se = n_se;
      frame(32'h100F, 16);
      wait_out(lat);
      frame(32'h101F, 16);
      wait_out(lat);
      chk("seq_after_two", 32'(n_se - b_se), 0);
      frame(32'h1030, 16);
      wait_out(lat);
      chk("seq_after_jump", 32'(n_se - b_se), 32'(SEQ_ON));
      frame(32'h1000, 16);
      wait_out(lat);
      chk("seq_total", 32'(n_se - b_se), 32'(SEQ_ON));
      chk("seq_wv_count", 32'(n_wv - b_wv), 4);
      chk("seq_last_data", 32'(data), 32'h000);
      if (SEQ_ON != 0) chk("seq_flagged_word", 32'(se_word), 32'h1030);

      chk("never_both", 32'(n_both), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
